chrom_eval_sequencer: RTL and testbench

//   Sequences one fitness evaluation of the evolved genetic circuit under HPS control.

---
 rtl/chrom_eval_sequencer.sv | 120 ++++++++++++
 tb/tb_chrom_eval_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/chrom_eval_sequencer.sv
// Sequences one fitness evaluation of the evolved circuit: load, then apply/settle/sample
// each test vector, accumulating per-output-bit mismatch counts for the HPS.
module chrom_eval_sequencer #(
    parameter int NUM_SEQ  = 16,
    parameter int DATA_W   = 8,
    parameter int SUM_W    = 32,
    parameter int SETTLE_W = 8
) (
    input  logic                      iClock,
    input  logic                      iResetN,
    input  logic                      iStartProcessing,
    input  logic                      iDoneProcessingFeedback,
    output logic                      oReadyToProcess,
    output logic                      oDoneProcessing,
    input  logic [NUM_SEQ*DATA_W-1:0] iInputSequence,
    input  logic [NUM_SEQ*DATA_W-1:0] iExpectedOutput,
    input  logic [SETTLE_W-1:0]       iSettleCycles,
    input  logic                      iStall,
    input  logic [3:0]                iStallIndex,
    output logic                      oCircuitLoad,
    output logic [DATA_W-1:0]         oCircuitInput,
    input  logic [DATA_W-1:0]         iCircuitOutput,
    output logic [DATA_W*SUM_W-1:0]   oErrorSums,
    output logic [2:0]                oState
);

    // state  | meaning
    // IDLE   | ready for a start request
    // LOAD   | circuit latches chromosome; sums/index cleared, vectors snapshotted
    // APPLY  | drive snapshot[index] to the circuit, load settle counter
    // SETTLE | count down settle cycles (debug stall may freeze here)
    // SAMPLE | accumulate mismatches for the current vector
    // DONE   | results valid, waiting for HPS acknowledge
    // ACK    | waiting for start and feedback to both drop
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] APPLY  = 3'd2;
    localparam logic [2:0] SETTLE = 3'd3;
    localparam logic [2:0] SAMPLE = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam logic [2:0] ACK    = 3'd6;

    localparam int IDX_W = $clog2(NUM_SEQ);
    localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(NUM_SEQ - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_ONE = SETTLE_W'(1);
    localparam logic [SUM_W-1:0]    SUM_ONE    = SUM_W'(1);

    logic [2:0]          state;
    logic [IDX_W-1:0]    idx;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [DATA_W-1:0]   in_snap  [NUM_SEQ];
    logic [DATA_W-1:0]   exp_snap [NUM_SEQ];
    logic [SUM_W-1:0]    sums     [DATA_W];
    logic                stall_hit;

    assign stall_hit = iStall && (idx == iStallIndex[IDX_W-1:0]);

    always_ff @(posedge iClock) begin
        if (!iResetN) begin
            state         <= IDLE;
            idx           <= '0;
            settle_cnt    <= '0;
            oCircuitInput <= '0;
            for (int k = 0; k < NUM_SEQ; k++) begin
                in_snap[k]  <= '0;
                exp_snap[k] <= '0;
            end
            for (int b = 0; b < DATA_W; b++) sums[b] <= '0;
        end else begin
            case (state)
                IDLE: if (iStartProcessing) state <= LOAD;
                LOAD: begin
                    idx <= '0;
                    for (int k = 0; k < NUM_SEQ; k++) begin
                        in_snap[k]  <= iInputSequence[k*DATA_W +: DATA_W];
                        exp_snap[k] <= iExpectedOutput[k*DATA_W +: DATA_W];
                    end
                    for (int b = 0; b < DATA_W; b++) sums[b] <= '0;
                    state <= APPLY;
                end
                APPLY: begin
                    oCircuitInput <= in_snap[idx];
                    settle_cnt    <= iSettleCycles;
                    state         <= (iSettleCycles == '0) ? SAMPLE : SETTLE;
                end
                SETTLE: if (!stall_hit) begin
                    settle_cnt <= settle_cnt - SETTLE_ONE;
                    if (settle_cnt == SETTLE_ONE) state <= SAMPLE;
                end
                SAMPLE: begin
                    // Saturate rather than wrap so a huge error never looks like a small one.
                    for (int b = 0; b < DATA_W; b++) begin
                        if ((iCircuitOutput[b] ^ exp_snap[idx][b]) && !(&sums[b]))
                            sums[b] <= sums[b] + SUM_ONE;
                    end
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= APPLY;
                    end
                end
                DONE: if (iDoneProcessingFeedback) state <= ACK;
                ACK:  if (!iDoneProcessingFeedback && !iStartProcessing) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        oErrorSums = '0;
        for (int b = 0; b < DATA_W; b++) oErrorSums[b*SUM_W +: SUM_W] = sums[b];
    end

    assign oReadyToProcess = (state == IDLE);
    assign oDoneProcessing = (state == DONE);
    assign oCircuitLoad    = (state == LOAD);
    assign oState          = state;

endmodule

// File: tb/tb_chrom_eval_sequencer.sv
// Self-checking bench for chrom_eval_sequencer: random vectors against a counting model
// of mismatches and a closed-form latency, plus handshake, stall and reset scenarios.
module tb_chrom_eval_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         fb;
    logic         ready;
    logic         done;
    logic [127:0] in_seq;
    logic [127:0] exp_seq;
    logic [7:0]   settle;
    logic         stall;
    logic [3:0]   stall_idx;
    logic         circ_load;
    logic [7:0]   circ_in;
    logic [7:0]   circ_out;
    logic [255:0] sums;
    logic [2:0]   state;

    logic [7:0]   circ_mask;
    logic [7:0]   vec  [16];
    logic [7:0]   expv [16];
    int           load_cnt = 0;
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    assign circ_out = circ_in ^ circ_mask;

    always @(negedge clk) if (circ_load) load_cnt++;

    chrom_eval_sequencer dut (
        .iClock                  (clk),
        .iResetN                 (rst_n),
        .iStartProcessing        (start),
        .iDoneProcessingFeedback (fb),
        .oReadyToProcess         (ready),
        .oDoneProcessing         (done),
        .iInputSequence          (in_seq),
        .iExpectedOutput         (exp_seq),
        .iSettleCycles           (settle),
        .iStall                  (stall),
        .iStallIndex             (stall_idx),
        .oCircuitLoad            (circ_load),
        .oCircuitInput           (circ_in),
        .iCircuitOutput          (circ_out),
        .oErrorSums              (sums),
        .oState                  (state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // mode 0: expected = input, 1: random expected
    task automatic new_vectors(input int mode);
        for (int k = 0; k < 16; k++) begin
            vec[k]  = 8'($urandom);
            expv[k] = (mode == 0) ? vec[k] : 8'($urandom);
            in_seq[k*8 +: 8]  = vec[k];
            exp_seq[k*8 +: 8] = expv[k];
        end
    endtask

    task automatic check_sums(input string tag);
        logic [7:0] diff;
        int         cnt [8];
        for (int b = 0; b < 8; b++) cnt[b] = 0;
        for (int k = 0; k < 16; k++) begin
            diff = (vec[k] ^ circ_mask) ^ expv[k];
            for (int b = 0; b < 8; b++) if (diff[b]) cnt[b]++;
        end
        for (int b = 0; b < 8; b++)
            check($sformatf("%s_sum%0d", tag, b), 64'(sums[b*32 +: 32]), 64'(cnt[b]));
    endtask

    // Raises start for the sampling edge, then counts edges until done (bounded).
    task automatic start_and_wait(input bit hold, input int budget, output int lat);
        start = 1'b1;
        tick(1);
        if (!hold) start = 1'b0;
        lat = 0;
        while (!done && lat < budget) begin
            tick(1);
            lat++;
        end
    endtask

    task automatic acknowledge();
        fb = 1'b1;
        tick(1);
        fb = 1'b0;
        tick(1);
    endtask

    int lat;
    int loads_before;

    initial begin
        rst_n = 1'b0; start = 1'b0; fb = 1'b0; settle = 8'd4;
        stall = 1'b0; stall_idx = 4'd0; circ_mask = 8'h00;
        in_seq = '0; exp_seq = '0;
        tick(3);
        rst_n = 1'b1;
        tick(10);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_state", 64'(state), 64'd0);
        check("rst_done",  64'(done),  64'd0);
        check("rst_sums",  64'(sums != '0), 64'd0);
        check("rst_noload", 64'(load_cnt), 64'd0);

        // identity circuit, expected = input, S=4
        new_vectors(0);
        circ_mask = 8'h00; settle = 8'd4;
        start_and_wait(1'b0, 200, lat);
        check("id_latency", 64'(lat), 64'd97);
        check("id_loads", 64'(load_cnt), 64'd1);
        check_sums("id");
        acknowledge();
        check("id_back_idle", 64'(ready), 64'd1);

        // inverting circuit, S=0
        new_vectors(0);
        circ_mask = 8'hFF; settle = 8'd0;
        start_and_wait(1'b0, 200, lat);
        check("inv_latency", 64'(lat), 64'd33);
        check_sums("inv");
        acknowledge();

        // random expected / random circuit, assorted settle counts
        for (int r = 0; r < 3; r++) begin
            new_vectors(1);
            circ_mask = 8'($urandom);
            settle = 8'($urandom_range(1, 6));
            start_and_wait(1'b0, 300, lat);
            check($sformatf("rnd%0d_latency", r), 64'(lat), 64'(1 + 16 * (settle + 2)));
            check_sums($sformatf("rnd%0d", r));
            acknowledge();
        end

        // handshake: start held high through DONE
        new_vectors(1);
        circ_mask = 8'($urandom); settle = 8'd1;
        loads_before = load_cnt;
        start_and_wait(1'b1, 200, lat);
        check("hs_done", 64'(done), 64'd1);
        check("hs_sums_stable_pre", 64'(state), 64'd5);
        tick(5);
        check("hs_still_done", 64'(state), 64'd5);
        check_sums("hs");
        fb = 1'b1; tick(1); fb = 1'b0; tick(4);
        check("hs_ack_hold", 64'(state), 64'd6);
        start = 1'b0; tick(1);
        check("hs_idle", 64'(state), 64'd0);
        check("hs_ready", 64'(ready), 64'd1);
        tick(5);
        check("hs_no_reload", 64'(load_cnt - loads_before), 64'd1);

        // debug stall at vector 5
        new_vectors(1);
        circ_mask = 8'($urandom); settle = 8'd3;
        stall = 1'b1; stall_idx = 4'd5;
        start = 1'b1; tick(1); start = 1'b0;
        tick(2 + 5 * 5 + 20);
        check("stall_state", 64'(state), 64'd3);
        check("stall_input", 64'(circ_in), 64'(vec[5]));
        tick(10);
        check("stall_hold", 64'(state), 64'd3);
        stall = 1'b0;
        lat = 0;
        while (!done && lat < 200) begin tick(1); lat++; end
        check("stall_done", 64'(done), 64'd1);
        check_sums("stall");
        acknowledge();

        // reset in SETTLE at index 9
        new_vectors(1);
        circ_mask = 8'($urandom); settle = 8'd4;
        start = 1'b1; tick(1); start = 1'b0;
        tick(57);
        check("mid_state", 64'(state), 64'd3);
        check("mid_input", 64'(circ_in), 64'(vec[9]));
        rst_n = 1'b0; tick(1); rst_n = 1'b1;
        check("rst_mid_state", 64'(state), 64'd0);
        check("rst_mid_sums",  64'(sums != '0), 64'd0);
        check("rst_mid_input", 64'(circ_in), 64'd0);
        check("rst_mid_ready", 64'(ready), 64'd1);
        new_vectors(1);
        circ_mask = 8'($urandom); settle = 8'd2;
        start_and_wait(1'b0, 200, lat);
        check("post_rst_latency", 64'(lat), 64'd65);
        check_sums("post_rst");
        acknowledge();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
